// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting controller for the HH:MM:SS clock counter.
// Two active-low push keys (mode, inc) are synchronized and debounced into
// single-cycle press pulses. These drive a RUN / SET_H / SET_M / COMMIT state
// machine that controls the counter's en/load inputs and its preset digits.
// Optional feature macro: CLOCK_SET_BLINK_EN blinks the digit pair being edited
// on 1 Hz ticks. Without it, blink_mask is tied to 0 and no flag register exists.

module clock_set_debounce #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_WIDTH  = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DB_CYCLES - 1);

    logic                sync1;
    logic                sync2;
    logic                held;
    logic [DB_WIDTH-1:0] cnt;

    // Two-flop synchronizer for the asynchronous key; idle level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // Count a stable low to fire one press pulse, then a stable high to re-arm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            held  <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (!held) begin
                if (sync2) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    held  <= 1'b1;
                    press <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                if (!sync2) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt  <= '0;
                    held <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

module clock_set_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_WIDTH  = 20,
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic [2:0] cur_hq1,
    input  logic [3:0] cur_hq0,
    input  logic [2:0] cur_mq1,
    input  logic [3:0] cur_mq0,
    output logic       en,
    output logic       load,
    output logic [2:0] hd1,
    output logic [3:0] hd0,
    output logic [2:0] md1,
    output logic [3:0] md0,
    output logic [1:0] mode,
    output logic [3:0] blink_mask
);

    localparam int              TO_W    = $clog2(TIMEOUT_S + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_H  = 2'd1,
        SET_M  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t          state;
    logic [TO_W-1:0] sec_cnt;
    logic            mode_press;
    logic            inc_press;
    logic            timeout_hit;
    logic            hour_ok;
    logic            min_ok;

    clock_set_debounce #(.DB_CYCLES(DB_CYCLES), .DB_WIDTH(DB_WIDTH)) u_db_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_mode),
        .press (mode_press)
    );

    clock_set_debounce #(.DB_CYCLES(DB_CYCLES), .DB_WIDTH(DB_WIDTH)) u_db_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_inc),
        .press (inc_press)
    );

    // A press in the same cycle as the final tick still counts as activity
    assign timeout_hit = tick_1hz && !inc_press && (sec_cnt == TO_LAST);

    // Live digits are trusted only when in range, so the preset stays legal
    assign hour_ok = ((cur_hq1 < 3'd2) && (cur_hq0 <= 4'd9)) ||
                     ((cur_hq1 == 3'd2) && (cur_hq0 <= 4'd3));
    assign min_ok  = (cur_mq1 <= 3'd5) && (cur_mq0 <= 4'd9);

    assign mode = state;

`ifdef CLOCK_SET_BLINK_EN
    logic       blink_flag;
    logic [3:0] blink_reg;
    assign blink_mask = blink_reg;
`else
    assign blink_mask = 4'b0000;
`endif

    // Set-mode state machine with registered en/load, preset digits and timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            en      <= 1'b1;
            load    <= 1'b0;
            hd1     <= 3'd0;
            hd0     <= 4'd0;
            md1     <= 3'd0;
            md0     <= 4'd0;
            sec_cnt <= '0;
`ifdef CLOCK_SET_BLINK_EN
            blink_flag <= 1'b0;
            blink_reg  <= 4'b0000;
`endif
        end else begin
            case (state)
                RUN: begin
                    en      <= 1'b1;
                    load    <= 1'b0;
                    sec_cnt <= '0;
                    if (mode_press) begin
                        state <= SET_H;
                        en    <= 1'b0;
                        hd1   <= hour_ok ? cur_hq1 : 3'd0;
                        hd0   <= hour_ok ? cur_hq0 : 4'd0;
                        md1   <= min_ok  ? cur_mq1 : 3'd0;
                        md0   <= min_ok  ? cur_mq0 : 4'd0;
                    end
                end
                SET_H: begin
                    if (mode_press) begin
                        state   <= SET_M;
                        sec_cnt <= '0;
                    end else if (timeout_hit) begin
                        state   <= RUN;
                        en      <= 1'b1;
                        sec_cnt <= '0;
                    end else if (inc_press) begin
                        sec_cnt <= '0;
                        if ((hd1 == 3'd2) && (hd0 == 4'd3)) begin
                            hd1 <= 3'd0;
                            hd0 <= 4'd0;
                        end else if (hd0 == 4'd9) begin
                            hd1 <= hd1 + 1'b1;
                            hd0 <= 4'd0;
                        end else begin
                            hd0 <= hd0 + 1'b1;
                        end
                    end else if (tick_1hz) begin
                        sec_cnt <= sec_cnt + 1'b1;
                    end
                end
                SET_M: begin
                    if (mode_press) begin
                        state   <= COMMIT;
                        load    <= 1'b1;
                        sec_cnt <= '0;
                    end else if (timeout_hit) begin
                        state   <= RUN;
                        en      <= 1'b1;
                        sec_cnt <= '0;
                    end else if (inc_press) begin
                        sec_cnt <= '0;
                        if (md0 == 4'd9) begin
                            md0 <= 4'd0;
                            md1 <= (md1 == 3'd5) ? 3'd0 : md1 + 1'b1;
                        end else begin
                            md0 <= md0 + 1'b1;
                        end
                    end else if (tick_1hz) begin
                        sec_cnt <= sec_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    if (tick_1hz) begin
                        state <= RUN;
                        en    <= 1'b1;
                        load  <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
`ifdef CLOCK_SET_BLINK_EN
            if ((state == SET_H) && !mode_press && !timeout_hit) begin
                if (tick_1hz) begin
                    blink_flag <= ~blink_flag;
                    blink_reg  <= {~blink_flag, ~blink_flag, 2'b00};
                end
            end else if ((state == SET_M) && !mode_press && !timeout_hit) begin
                if (tick_1hz) begin
                    blink_flag <= ~blink_flag;
                    blink_reg  <= {2'b00, ~blink_flag, ~blink_flag};
                end
            end else begin
                blink_flag <= 1'b0;
                blink_reg  <= 4'b0000;
            end
`endif
        end
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the HH:MM:SS digital clock counter. Converts two debounced push-button keys into a set-mode state machine and drives the counter's `en` / `load` inputs and its hour/minute preset digits. It also produces a digit-blank mask for the 7-segment drivers. Runs on the 50 MHz board clock; `tick_1hz` marks the counter's 1 Hz clock edge.

## Interface

Parameters:
- `DB_CYCLES`, 1000000: consecutive stable-low cycles for a key press to register (20 ms at 50 MHz).
- `DB_WIDTH`, 20: debounce counter width; must hold `DB_CYCLES`.
- `TIMEOUT_S`, 30: seconds with no key press in a set state before abort.

Ports:
- `clk` input 1: 50 MHz clock.
- `rst_n` input 1: asynchronous active-low reset.
- `tick_1hz` input 1: one-cycle strobe coincident with the counter's 1 Hz edge.
- `key_mode` input 1: raw key, active-low, asynchronous.
- `key_inc` input 1: raw key, active-low, asynchronous.
- `cur_hq1[2:0]`, `cur_hq0[3:0]`, `cur_mq1[2:0]`, `cur_mq0[3:0]` input: live counter digits (BCD).
- `en` output 1: counter enable.
- `load` output 1: counter parallel load.
- `hd1[2:0]`, `hd0[3:0]`, `md1[2:0]`, `md0[3:0]` output: preset digits (BCD).
- `mode` output 2: state encoding, 0=RUN, 1=SET_H, 2=SET_M, 3=COMMIT.
- `blink_mask` output 4: per-digit blank, bit 3..0 = HEX7..HEX4 (high = blank).

## Operation

- **Key path:** 2-flop synchronizer, then debounce counter. A press registers when the synced level has been low for `DB_CYCLES` consecutive cycles. Any high sample clears the counter. Each press yields exactly one 1-cycle pulse. The key must return high for `DB_CYCLES` cycles before the next press can register. There is no auto-repeat.
- **RUN:** `en`=1, `load`=0. A mode pulse latches the `cur_*` hour/minute digits into the preset registers and moves to SET_H.
- **SET_H:** `en`=0, so the counter holds. An inc pulse adds 1 to the hour: 23 wraps to 00, x9 wraps to (x+1)0. A mode pulse moves to SET_M.
- **SET_M:** `en`=0. An inc pulse adds 1 to the minute: 59 wraps to 00, with no carry into the hour. A mode pulse moves to COMMIT.
- **COMMIT:** `en`=0, `load`=1, held until the first `tick_1hz` seen while in COMMIT. On that tick, go to RUN, with `load` falling the next cycle. The counter therefore samples `load` on exactly one 1 Hz edge; seconds load as 00.
- **Timeout:** a seconds counter clears on any key pulse and increments on `tick_1hz` in SET_H/SET_M. On reaching `TIMEOUT_S`, go to RUN with no load; the preset is discarded.
- **Simultaneous pulses:** mode and inc in the same cycle means mode wins and inc is dropped.
- **Keys in COMMIT:** ignored.
- **Preset digits:** always within BCD range; the hour never exceeds 23 and the minute never exceeds 59.

## Timing

- **Reset values:** state RUN. `en`=1, `load`=0, all preset digits 0, `mode`=0, `blink_mask`=0. Debounce and timeout counters are 0.
- **Outputs:** all registered.
- **Press latency:** raw key low to press pulse is `DB_CYCLES`+2 cycles. The state or digit update is visible on the cycle after the pulse.
- **COMMIT duration:** 1 to 50,000,000 cycles, depending on tick phase.
- **Reset asserted mid-COMMIT:** `load` drops immediately (asynchronous) and no load occurs.

## Configuration

- **`CLOCK_SET_BLINK_EN` defined:** a blink flag toggles on each `tick_1hz` while in SET_H/SET_M and clears on entry to those states.
  - In SET_H, `blink_mask` = {flag, flag, 0, 0}.
  - In SET_M, `blink_mask` = {0, 0, flag, flag}.
  - In RUN and COMMIT, `blink_mask` = 0.
- **Not defined:** `blink_mask` is constant 0 and the flag register is absent.

## Test plan

Run the bench with `DB_CYCLES`=4.

1. **Bounce rejection:** `key_inc` low 3 cycles, high, then low 3 cycles in SET_H -> no increment. Then low 4 cycles -> exactly one increment.
2. **Preset latch and hour wrap:** counter at 23:58. Mode, then inc -> preset 00:58 with `mode`=1 and `en`=0.
3. **Minute wrap:** from 00:58, mode then 2× inc -> minute 00, hour unchanged at 00.
4. **Commit:** mode in SET_M -> `load`=1 held across cycles until `tick_1hz`. `load`=0 and `en`=1 one cycle after the tick; `mode`=0.
5. **Timeout:** in SET_H with `TIMEOUT_S`=3, issue 3 ticks with no key -> RUN, `load` never asserted, `en`=1.
6. **Simultaneous and reset:** mode+inc pulses in the same cycle in SET_H -> SET_M, hour unchanged. Pulse `rst_n` low during COMMIT -> `load`=0 immediately and all outputs at reset values.
